// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the IF/ID/EX pipeline front end and its hazard sequencer.
// The master side is the pipeline; the slave side is the sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_ra;
  logic [REG_W-1:0] id_rb;
  logic             id_uses_ra;
  logic             id_uses_rb;
  logic             id_is_div;
  logic             ex_valid;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd;
  logic             branch_taken;
  logic             stall_clr;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       hz_state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_ra, id_rb, id_uses_ra, id_uses_rb, id_is_div,
    output ex_valid, ex_is_load, ex_rd, branch_taken, stall_clr,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, hz_state, stall_cnt
  );

  modport slave (
    input  id_valid, id_ra, id_rb, id_uses_ra, id_uses_rb, id_is_div,
    input  ex_valid, ex_is_load, ex_rd, branch_taken, stall_clr,
    output pc_en, ifid_en, ifid_flush, idex_bubble, hz_state, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard sequencer: load-use stalls, divide occupancy and branch flushes,
// with a saturating count of bubble cycles.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int LOAD_BUBBLES = 1,
  parameter int DIV_LAT      = 4,
  parameter int FLUSH_CYC    = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);
  localparam int MAX_A = (LOAD_BUBBLES > DIV_LAT) ? LOAD_BUBBLES : DIV_LAT;
  localparam int MAX_V = (MAX_A > FLUSH_CYC) ? MAX_A : FLUSH_CYC;
  localparam int CW    = (MAX_V > 2) ? $clog2(MAX_V) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    DIV_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             pc_en, ifid_en, ifid_flush, idex_bubble;

  // Per-source match against the load destination in EX
  logic [REG_W-1:0] src_idx [2];
  logic [1:0]       src_use;
  logic [1:0]       src_hit;
  logic             ld_hz;

  assign src_idx[0] = hz.id_ra;
  assign src_idx[1] = hz.id_rb;
  assign src_use    = {hz.id_uses_rb, hz.id_uses_ra};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] & (src_idx[gi] == hz.ex_rd);
    end
  endgenerate

  assign ld_hz = hz.id_valid & hz.ex_valid & hz.ex_is_load & (|src_hit);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (hz.branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYC > 1) begin
        state_next = FLUSH;
        cnt_next   = CW'(FLUSH_CYC - 2);
      end else begin
        state_next = RUN;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (ld_hz) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_next = LD_STALL;
              cnt_next   = CW'(LOAD_BUBBLES - 2);
            end
          end else if (hz.id_valid && hz.id_is_div && DIV_LAT > 1) begin
            // The div itself issues this cycle; the wait covers its remaining EX cycles
            state_next = DIV_WAIT;
            cnt_next   = CW'(DIV_LAT - 2);
          end
        end
        LD_STALL, DIV_WAIT: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (cnt_reg == '0) state_next = RUN;
          else               cnt_next   = cnt_reg - CW'(1);
        end
        default: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (cnt_reg == '0) state_next = RUN;
          else               cnt_next   = cnt_reg - CW'(1);
        end
      endcase
    end
    if (!rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= RUN;
      cnt_reg       <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (hz.stall_clr)
        stall_cnt_reg <= '0;
      else if (idex_bubble && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.hz_state    = rst ? state_reg : RUN;
  assign hz.stall_cnt   = stall_cnt_reg;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected outputs queued per cycle,
// compared at the falling edge with immediate assertions.
module tb_pipeline_hazard_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [15:0] exp_cnt;

  typedef struct packed {
    logic        pc;
    logic        ie;
    logic        fl;
    logic        bb;
    logic [1:0]  hzs;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  pipeline_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) bus ();

  pipeline_hazard_ctrl #(
    .REG_W(4), .LOAD_BUBBLES(1), .DIV_LAT(4), .FLUSH_CYC(2), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic idv, input logic [3:0] ra, input logic [3:0] rb,
                       input logic ura, input logic urb, input logic dv,
                       input logic exv, input logic exl, input logic [3:0] rd,
                       input logic br, input logic clr);
    bus.id_valid     = idv;
    bus.id_ra        = ra;
    bus.id_rb        = rb;
    bus.id_uses_ra   = ura;
    bus.id_uses_rb   = urb;
    bus.id_is_div    = dv;
    bus.ex_valid     = exv;
    bus.ex_is_load   = exl;
    bus.ex_rd        = rd;
    bus.branch_taken = br;
    bus.stall_clr    = clr;
  endtask

  // One cycle: queue the expectation, compare mid-cycle, then advance the counter model.
  task automatic chk(input string tag, input logic pc, input logic ie, input logic fl,
                     input logic bb, input logic [1:0] hzs, input bit quiet = 1'b0);
    exp_t e;
    logic [5:0] got;
    e.pc = pc; e.ie = ie; e.fl = fl; e.bb = bb; e.hzs = hzs; e.cnt = exp_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    e   = exp_q.pop_front();
    got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.hz_state};
    checks++;
    assert (got === {e.pc, e.ie, e.fl, e.bb, e.hzs}) else begin
      failures++;
      $error("FAIL %s ctrl{pc,ie,fl,bb,st} got=%b expected=%b", tag, got,
             {e.pc, e.ie, e.fl, e.bb, e.hzs});
    end
    checks++;
    assert (bus.stall_cnt === e.cnt) else begin
      failures++;
      $error("FAIL %s stall_cnt got=%0d expected=%0d", tag, bus.stall_cnt, e.cnt);
    end
    if (!quiet)
      $display("step %-12s pc_en=%b ifid_en=%b flush=%b bubble=%b state=%0d stall_cnt=%0d",
               tag, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
               bus.hz_state, bus.stall_cnt);
    @(posedge clk);
    if (!rst || bus.stall_clr) exp_cnt = 16'd0;
    else if (bb && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 16'd0;
    rst      = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Reset held for two edges
    chk("rst_a", 0, 0, 1, 1, 0);
    chk("rst_b", 0, 0, 1, 1, 0);
    rst = 1'b1;
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("run_idle", 1, 1, 0, 0, 0);

    // Load-use on Ra, then the stall clears
    drive(1, 4, 7, 1, 0, 0, 1, 1, 4, 0, 0);
    chk("ld_hz_ra", 0, 0, 0, 1, 0);
    drive(1, 4, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("ld_after", 1, 1, 0, 0, 0);
    drive(1, 5, 4, 1, 0, 0, 1, 1, 4, 0, 0);
    chk("rb_unused", 1, 1, 0, 0, 0);
    drive(1, 5, 4, 1, 1, 0, 1, 1, 4, 0, 0);
    chk("ld_hz_rb", 0, 0, 0, 1, 0);
    drive(0, 4, 4, 1, 1, 0, 1, 1, 4, 0, 0);
    chk("id_invalid", 1, 1, 0, 0, 0);
    drive(1, 4, 4, 1, 1, 0, 1, 0, 4, 0, 0);
    chk("ex_not_load", 1, 1, 0, 0, 0);

    // Divide occupancy; a load-use pattern during the wait is ignored
    drive(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("div_issue", 1, 1, 0, 0, 0);
    drive(1, 4, 4, 1, 1, 1, 1, 1, 4, 0, 0);
    chk("div_w1", 0, 0, 0, 1, 2);
    chk("div_w2", 0, 0, 0, 1, 2);
    chk("div_w3", 0, 0, 0, 1, 2);
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("div_run", 1, 1, 0, 0, 0);

    // Taken branch from RUN
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0);
    chk("br_c1", 1, 1, 1, 1, 0);
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("br_c2", 1, 1, 1, 1, 3);
    chk("br_run", 1, 1, 0, 0, 0);

    // Branch aborts a divide wait
    drive(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("div2_issue", 1, 1, 0, 0, 0);
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("div2_w1", 0, 0, 0, 1, 2);
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0);
    chk("div2_br", 1, 1, 1, 1, 2);
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("div2_flush", 1, 1, 1, 1, 3);
    chk("div2_run", 1, 1, 0, 0, 0);

    // Branch beats a same-cycle load-use hazard
    drive(1, 6, 0, 1, 0, 0, 1, 1, 6, 1, 0);
    chk("ldbr", 1, 1, 1, 1, 0);
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("ldbr_flush", 1, 1, 1, 1, 3);
    chk("ldbr_run", 1, 1, 0, 0, 0);

    // Clear wins over increment, then saturate the counter
    drive(1, 4, 0, 1, 0, 0, 1, 1, 4, 0, 1);
    chk("clr_bubble", 0, 0, 0, 1, 0);
    drive(1, 4, 0, 1, 0, 0, 1, 1, 4, 0, 0);
    for (int i = 0; i < 65537; i++) chk("preload", 0, 0, 0, 1, 0, 1'b1);
    $display("step preload     65537 load-use bubbles, stall_cnt=%0d", bus.stall_cnt);
    checks++;
    assert (bus.stall_cnt === 16'hFFFF) else begin
      failures++;
      $error("FAIL sat_hold stall_cnt got=%0d expected=%0d", bus.stall_cnt, 16'hFFFF);
    end
    chk("sat_more", 0, 0, 0, 1, 0);
    drive(1, 4, 0, 1, 0, 0, 1, 1, 4, 0, 1);
    chk("sat_clr", 0, 0, 0, 1, 0);
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("clr_zero", 1, 1, 0, 0, 0);

    // Reset in the middle of a divide wait
    drive(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("div3_issue", 1, 1, 0, 0, 0);
    drive(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("div3_w1", 0, 0, 0, 1, 2);
    rst = 1'b0;
    chk("rst_mid", 0, 0, 1, 1, 0);
    rst = 1'b1;
    chk("rst_run", 1, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
